// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: instruction classes, load/store width codes,
// FSM states and the byte-count helper.
package mem_access_pkg;

  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] SAVE = 7'b0100011;
  localparam logic [6:0] JMPC = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  // Index of the final byte of an access; unlisted width codes behave as a word.
  function automatic logic [1:0] last_index(input logic [2:0] f3);
    logic [1:0] idx;
    unique case (f3)
      F3_B, F3_BU: idx = 2'd0;
      F3_H, F3_HU: idx = 2'd1;
      default:     idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled load data according to the funct3 width code.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] val
);

  always_comb begin
    val = raw;
    unique case (funct3)
      F3_B:    val = {{24{raw[7]}}, raw[7:0]};
      F3_H:    val = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   val = {24'd0, raw[7:0]};
      F3_HU:   val = {16'd0, raw[15:0]};
      default: val = raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results straight to writeback and serialises
// loads/stores into little-endian byte transactions on a simple req/ack memory port.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              valid_in,
  input  logic [6:0]        ins_type,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd_addr,
  input  logic [31:0]       alu_val,
  input  logic [31:0]       store_val,
  output logic              stall_req,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              valid_out,
  output logic [4:0]        rd_addr_out,
  output logic [31:0]       rd_val_out,
  output logic [6:0]        ins_type_out
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [6:0]        ins_q, ins_d;
  logic              valid_out_q, valid_out_d;
  logic [4:0]        rd_addr_out_q, rd_addr_out_d;
  logic [31:0]       rd_val_out_q, rd_val_out_d;
  logic [6:0]        ins_type_out_q, ins_type_out_d;

  logic        is_ls_in;
  logic        is_save;
  logic        in_access;
  logic [31:0] data_merged;
  logic [31:0] ext_val;

  assign is_ls_in  = (ins_type == LOAD) || (ins_type == SAVE);
  assign is_save   = (ins_q == SAVE);
  assign in_access = (state_q == StAccess);

  // Memory port is only driven while actively accessing and the pipeline is not frozen.
  assign mem_req   = in_access && rdy_in;
  assign mem_we    = mem_req && is_save;
  assign mem_addr  = in_access ? base_q + ADDR_W'(idx_q) : '0;
  assign mem_wdata = in_access ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;
  assign stall_req = rst_in && (in_access || ((state_q == StIdle) && valid_in && is_ls_in));

  assign valid_out    = valid_out_q;
  assign rd_addr_out  = rd_addr_out_q;
  assign rd_val_out   = rd_val_out_q;
  assign ins_type_out = ins_type_out_q;

  // Load data with the byte arriving this cycle already merged in, so the final
  // ack can produce the extended result without an extra cycle.
  always_comb begin
    data_merged = data_q;
    data_merged[{idx_q, 3'b000} +: 8] = mem_rdata;
  end

  load_extend u_load_extend (
    .funct3 (f3_q),
    .raw    (data_merged),
    .val    (ext_val)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    base_d         = base_q;
    wdata_d        = wdata_q;
    data_d         = data_q;
    f3_d           = f3_q;
    rd_d           = rd_q;
    ins_d          = ins_q;
    valid_out_d    = valid_out_q;
    rd_addr_out_d  = rd_addr_out_q;
    rd_val_out_d   = rd_val_out_q;
    ins_type_out_d = ins_type_out_q;

    if (rdy_in) begin
      valid_out_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_in) begin
            if (is_ls_in) begin
              base_d  = ADDR_W'(alu_val);
              wdata_d = store_val;
              data_d  = 32'd0;
              f3_d    = funct3;
              rd_d    = rd_addr;
              ins_d   = ins_type;
              idx_d   = 2'd0;
              state_d = StAccess;
            end else begin
              valid_out_d    = 1'b1;
              rd_addr_out_d  = rd_addr;
              rd_val_out_d   = alu_val;
              ins_type_out_d = ins_type;
            end
          end
        end
        StAccess: begin
          if (mem_ack) begin
            if (!is_save) begin
              data_d = data_merged;
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == last_index(f3_q)) begin
              state_d        = StDone;
              valid_out_d    = 1'b1;
              rd_addr_out_d  = rd_q;
              rd_val_out_d   = is_save ? 32'd0 : ext_val;
              ins_type_out_d = ins_q;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= StIdle;
      idx_q          <= 2'd0;
      base_q         <= '0;
      wdata_q        <= 32'd0;
      data_q         <= 32'd0;
      f3_q           <= 3'd0;
      rd_q           <= 5'd0;
      ins_q          <= 7'd0;
      valid_out_q    <= 1'b0;
      rd_addr_out_q  <= 5'd0;
      rd_val_out_q   <= 32'd0;
      ins_type_out_q <= 7'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      base_q         <= base_d;
      wdata_q        <= wdata_d;
      data_q         <= data_d;
      f3_q           <= f3_d;
      rd_q           <= rd_d;
      ins_q          <= ins_d;
      valid_out_q    <= valid_out_d;
      rd_addr_out_q  <= rd_addr_out_d;
      rd_val_out_q   <= rd_val_out_d;
      ins_type_out_q <= ins_type_out_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: ALU passthrough, byte-serial loads/stores,
// extension, address wrap, freeze via rdy_in and reset abort.
module tb_mem_access;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SAVE = 7'b0100011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        valid_in;
  logic [6:0]  ins_type;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic [31:0] alu_val;
  logic [31:0] store_val;
  logic        stall_req;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        valid_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_val_out;
  logic [6:0]  ins_type_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_access #(.ADDR_W(32)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .valid_in     (valid_in),
    .ins_type     (ins_type),
    .funct3       (funct3),
    .rd_addr      (rd_addr),
    .alu_val      (alu_val),
    .store_val    (store_val),
    .stall_req    (stall_req),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .valid_out    (valid_out),
    .rd_addr_out  (rd_addr_out),
    .rd_val_out   (rd_val_out),
    .ins_type_out (ins_type_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One complete LOAD/SAVE transaction acknowledged every cycle; rbytes holds read bytes LSB first.
  task automatic run_access(input string tag, input logic [6:0] ins, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sval, input int n,
                            input logic [31:0] rbytes, input logic [31:0] exp_val);
    logic [31:0] exp_addr;
    valid_in  = 1'b1;
    ins_type  = ins;
    funct3    = f3;
    rd_addr   = 5'd9;
    alu_val   = addr;
    store_val = sval;
    #1;
    check({tag, " stall_on_accept"}, 32'(stall_req), 32'd1);
    check({tag, " no_req_in_idle"}, 32'(mem_req), 32'd0);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = rbytes[8*i +: 8];
      #1;
      exp_addr = addr + 32'(i);
      check({tag, " mem_req"}, 32'(mem_req), 32'd1);
      check({tag, " mem_we"}, 32'(mem_we), 32'(ins == OP_SAVE));
      check({tag, " mem_addr"}, mem_addr, exp_addr);
      check({tag, " stall_access"}, 32'(stall_req), 32'd1);
      check({tag, " valid_access"}, 32'(valid_out), 32'd0);
      if (ins == OP_SAVE) check({tag, " mem_wdata"}, 32'(mem_wdata), 32'(sval[8*i +: 8]));
      tick();
    end
    mem_ack = 1'b0;
    #1;
    check({tag, " valid_done"}, 32'(valid_out), 32'd1);
    check({tag, " rd_val"}, rd_val_out, exp_val);
    check({tag, " rd_addr_out"}, 32'(rd_addr_out), 32'd9);
    check({tag, " ins_type_out"}, 32'(ins_type_out), 32'(ins));
    check({tag, " stall_done"}, 32'(stall_req), 32'd0);
    check({tag, " req_done"}, 32'(mem_req), 32'd0);
    tick();
    check({tag, " valid_after"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    rst_in    = 1'b0;
    rdy_in    = 1'b1;
    valid_in  = 1'b0;
    ins_type  = 7'd0;
    funct3    = 3'd0;
    rd_addr   = 5'd0;
    alu_val   = 32'd0;
    store_val = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 8'd0;
    #1;
    check("reset valid_out", 32'(valid_out), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset stall_req", 32'(stall_req), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset rd_val_out", rd_val_out, 32'd0);
    check("reset ins_type_out", 32'(ins_type_out), 32'd0);
    tick();
    tick();
    rst_in = 1'b1;
    tick();

    // ALU passthrough: one-cycle latency, never stalls.
    valid_in = 1'b1;
    ins_type = OP_ADD;
    rd_addr  = 5'd7;
    alu_val  = 32'h55;
    #1;
    check("add stall", 32'(stall_req), 32'd0);
    tick();
    valid_in = 1'b0;
    check("add valid", 32'(valid_out), 32'd1);
    check("add rd_val", rd_val_out, 32'h55);
    check("add rd_addr", 32'(rd_addr_out), 32'd7);
    check("add stall_after", 32'(stall_req), 32'd0);
    tick();
    check("add valid_drop", 32'(valid_out), 32'd0);

    run_access("lw", OP_LOAD, 3'b010, 32'h1000, 32'd0, 4, 32'h12345678, 32'h12345678);
    run_access("lb", OP_LOAD, 3'b000, 32'h0040, 32'd0, 1, 32'h00000080, 32'hFFFFFF80);
    run_access("lbu", OP_LOAD, 3'b100, 32'h0040, 32'd0, 1, 32'h00000080, 32'h00000080);
    run_access("sh", OP_SAVE, 3'b001, 32'h0003, 32'h0000ABCD, 2, 32'd0, 32'd0);
    run_access("lh_wrap", OP_LOAD, 3'b001, 32'hFFFFFFFF, 32'd0, 2, 32'h00008234, 32'hFFFF8234);
    run_access("lhu", OP_LOAD, 3'b101, 32'h0010, 32'd0, 2, 32'h00008234, 32'h00008234);
    run_access("f3_011_word", OP_LOAD, 3'b011, 32'h0020, 32'd0, 4, 32'hCAFEBABE, 32'hCAFEBABE);

    // Wait state and valid_in ignored while accessing.
    valid_in = 1'b1;
    ins_type = OP_LOAD;
    funct3   = 3'b000;
    rd_addr  = 5'd3;
    alu_val  = 32'h0100;
    tick();
    ins_type = OP_ADD;
    alu_val  = 32'h0777;
    #1;
    check("wait mem_addr", mem_addr, 32'h0100);
    tick();
    check("wait no_valid", 32'(valid_out), 32'd0);
    check("wait addr_hold", mem_addr, 32'h0100);
    mem_ack   = 1'b1;
    mem_rdata = 8'h7F;
    tick();
    mem_ack  = 1'b0;
    check("wait load_result", rd_val_out, 32'h0000007F);
    check("wait load_valid", 32'(valid_out), 32'd1);
    tick();
    check("done ignores valid_in", 32'(valid_out), 32'd0);
    tick();
    check("idle accepts add", rd_val_out, 32'h0777);
    valid_in = 1'b0;
    tick();

    // Freeze with rdy_in low mid-word, then reset aborts the access.
    valid_in = 1'b1;
    ins_type = OP_LOAD;
    funct3   = 3'b010;
    rd_addr  = 5'd4;
    alu_val  = 32'h2000;
    tick();
    valid_in  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h11;
    tick();
    mem_rdata = 8'h22;
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frozen mem_req", 32'(mem_req), 32'd0);
      check("frozen mem_addr", mem_addr, 32'h2002);
      tick();
    end
    rdy_in  = 1'b1;
    mem_ack = 1'b0;
    #1;
    check("thaw mem_addr", mem_addr, 32'h2002);
    check("thaw mem_req", 32'(mem_req), 32'd1);
    rst_in = 1'b0;
    #1;
    check("abort mem_req", 32'(mem_req), 32'd0);
    check("abort valid_out", 32'(valid_out), 32'd0);
    check("abort stall", 32'(stall_req), 32'd0);
    tick();
    rst_in = 1'b1;
    tick();
    check("post_reset mem_req", 32'(mem_req), 32'd0);
    check("post_reset valid_out", 32'(valid_out), 32'd0);
    valid_in = 1'b1;
    ins_type = OP_ADD;
    rd_addr  = 5'd2;
    alu_val  = 32'h0000_00A5;
    tick();
    valid_in = 1'b0;
    check("post_reset idle add", rd_val_out, 32'h0000_00A5);
    check("post_reset idle valid", 32'(valid_out), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have port clk_in  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rdy_in  input  1  global enable; low freezes the block.
REQ-005 SHALL have port valid_in  input  1  EX result present this cycle.
REQ-006 SHALL have port ins_type  input  7  instruction class (`LOAD, `SAVE, `JMPC, others).
REQ-007 SHALL have port funct3  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port rd_addr  input  5  destination register.
REQ-009 SHALL have port alu_val  input  32  effective address (LOAD/SAVE) or ALU result (others).
REQ-010 SHALL have port store_val  input  32  store data (SAVE only).
REQ-011 SHALL have port stall_req  output  1  upstream hold request.
REQ-012 SHALL have port mem_req  output  1  byte access request to memory controller.
REQ-013 SHALL have port mem_we  output  1  1 = byte write, 0 = byte read.
REQ-014 SHALL have port mem_addr  output  ADDR_W  byte address.
REQ-015 SHALL have port mem_wdata  output  8  write byte.
REQ-016 SHALL have port mem_ack  input  1  byte accepted this cycle; for reads, mem_rdata valid this cycle.
REQ-017 SHALL have port mem_rdata  input  8  read byte.
REQ-018 SHALL have ports valid_out/rd_addr_out/rd_val_out/ins_type_out  output  1/5/32/7  registered result to WB.

Function
REQ-019 SHALL implement states IDLE, ACCESS, DONE.
REQ-020 In IDLE with valid_in and ins_type not `LOAD/`SAVE, SHALL register rd_addr, alu_val, ins_type to outputs with valid_out=1 next cycle (1-cycle latency, no stall).
REQ-021 In IDLE with valid_in and `LOAD/`SAVE, SHALL latch base address, store_val, funct3, rd_addr, ins_type, clear byte index, go to ACCESS; stall_req SHALL be asserted combinationally that same cycle.
REQ-022 Byte count SHALL be 1 (B/BU), 2 (H/HU), 4 (W); other funct3 values SHALL be treated as W.
REQ-023 In ACCESS, mem_req=1, mem_we=(SAVE), mem_addr=base+index modulo 2^ADDR_W, mem_wdata=store_val[8*index+:8].
REQ-024 Each cycle with mem_req and mem_ack SHALL advance index by 1; reads SHALL store mem_rdata into data[8*index+:8] (little-endian).
REQ-025 Ack on the final byte SHALL transition to DONE; mem_req SHALL be 0 in DONE.
REQ-026 In DONE SHALL present valid_out=1 for one cycle with rd_val_out sign-extended (B/H) or zero-extended (BU/HU/W) load data; for SAVE rd_val_out=0, then return to IDLE.
REQ-027 stall_req SHALL stay 1 through ACCESS and deassert in DONE; valid_in SHALL be ignored outside IDLE.
REQ-028 Misaligned addresses SHALL be legal; no alignment fault.
REQ-029 valid_out SHALL be 0 in every cycle not covered by REQ-020/REQ-026.
REQ-030 While rdy_in=0, all registers SHALL hold, mem_req SHALL be 0, mem_ack SHALL be ignored.

Reset
REQ-031 On rst_in low, SHALL immediately enter IDLE and clear index, valid_out, mem_req, mem_we, stall_req, rd_addr_out, rd_val_out, mem_addr, mem_wdata to 0 and ins_type_out to 0.
REQ-032 Reset during ACCESS SHALL abort; no further bytes requested, no result produced.

Structure
REQ-033 ins_type encodings (`LOAD, `SAVE, `JMPC) and funct3 width codes SHALL live in the shared defines file.
REQ-034 Load extension SHALL be a sub-module load_extend (funct3 + 32-bit raw -> 32-bit value, combinational).

Verification
REQ-035 LW addr 0x1000, acks with 0x78,0x56,0x34,0x12 -> 4 reads at 0x1000..0x1003, valid_out one cycle after 4th ack, rd_val_out=0x12345678.
REQ-036 LB read byte 0x80 -> rd_val_out=0xFFFFFF80; LBU same byte -> 0x00000080.
REQ-037 SH store_val=0x0000ABCD addr 0x3 -> writes 0xCD@0x3, 0xAB@0x4, mem_we=1, rd_val_out=0.
REQ-038 LH addr 0xFFFFFFFF -> second access at 0x00000000 (wrap).
REQ-039 ADD result 0x55 rd=7 -> valid_out next cycle, rd_val_out=0x55, stall_req never 1.
REQ-040 LW with rdy_in low for 3 cycles after 2nd ack, then rst_in pulsed in ACCESS -> no index change while frozen; after reset mem_req=0, valid_out=0, state IDLE.
